// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encoding
// and the default byte returned for unloaded or masked addresses.
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [7:0] FILL_DEFAULT = 8'h00;

endpackage : instr_mem_loader_pkg

// File: rtl/instr_mem_loader_ram.sv
// Program storage: one synchronous write port, one asynchronous read port.
// It has no reset, so it can map onto distributed RAM. Stale contents are
// hidden by the loader's length mask instead of being cleared.
module instr_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write port: one byte per accepted load transfer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Zero-latency read, so the core sees the byte in the same cycle as its pc.
    assign rd_data = mem[rd_addr];

endmodule : instr_ram

// File: rtl/instr_mem_loader.sv
// Program memory for the 8-bit core. It is loaded byte-serially over a
// valid/ready port, and it holds the core in reset until a complete program
// is resident.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no program resident, core held, port closed
//   ST_LOADING | accepting bytes, core held, busy
//   ST_RUN     | program resident, core released, reads unmasked
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int         DEPTH = 256,
    parameter logic [7:0] FILL  = FILL_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic [7:0] pc,
    output logic [7:0] instruction,
    output logic       cpu_hold,
    output logic       busy,
    output logic [8:0] length
);

    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    state_t     state_q;
    state_t     state_d;
    logic [8:0] ptr_q;
    logic [8:0] ptr_inc;
    logic [8:0] length_q;
    logic       cpu_hold_q;
    logic       wr_en;
    logic       end_xfer;
    logic       in_range;
    logic [7:0] rd_data;

    assign load_ready = (state_q == ST_LOADING);
    assign busy       = (state_q == ST_LOADING);
    assign cpu_hold   = cpu_hold_q;
    assign length     = length_q;

    assign ptr_inc  = ptr_q + 9'd1;
    // A load_start in the same cycle discards any byte on the port.
    assign wr_en    = load_valid && load_ready && !load_start;
    // The transfer that fills the memory ends the load even without load_last.
    assign end_xfer = wr_en && (load_last || (ptr_inc == DEPTH_L));

    // Next-state logic. load_start always (re)enters LOADING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) state_d = ST_LOADING;
            end
            ST_LOADING: begin
                if (load_start)    state_d = ST_LOADING;
                else if (end_xfer) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (load_start) state_d = ST_LOADING;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register. cpu_hold is registered from the next state, so it drops on the edge entering RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cpu_hold_q <= (state_d != ST_RUN);
        end
    end

    // Write pointer and loaded length. Both clear whenever a load (re)starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q    <= 9'd0;
            length_q <= 9'd0;
        end else if (load_start) begin
            ptr_q    <= 9'd0;
            length_q <= 9'd0;
        end else if (wr_en) begin
            ptr_q    <= ptr_inc;
            length_q <= ptr_inc;
        end
    end

    instr_ram #(
        .DEPTH (DEPTH),
        .AW    (8)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ptr_q[7:0]),
        .wr_data (load_data),
        .rd_addr (pc),
        .rd_data (rd_data)
    );

    // Bytes outside the loaded program, or any byte read before RUN, return FILL.
    assign in_range    = (state_q == ST_RUN) && ({1'b0, pc} < length_q);
    assign instruction = in_range ? rd_data : FILL;

endmodule : instr_mem_loader

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic       cpu_hold;
    logic       busy;
    logic [8:0] length;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .pc          (pc),
        .instruction (instruction),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .length      (length)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Waits for a transfer while holding the byte steady. The wait is bounded.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        n = 0;
        while (!load_ready && n < 16) begin
            step();
            n++;
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_timeout: load_ready=%b required 1", load_ready);
        end
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Each address pops its expected byte from the scoreboard.
    task automatic drain_scoreboard(input string name);
        int i;
        logic [7:0] e;
        i = 0;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            pc = 8'(i);
            #1;
            checks++;
            if (instruction !== e) begin
                errors++;
                $display("FAIL %s pc=%0d: instruction=%h required %h", name, i, instruction, e);
            end
            i++;
        end
    endtask

    task automatic check_pc(input string name, input logic [7:0] a, input logic [7:0] e);
        pc = a;
        #1;
        checks++;
        if (instruction !== e) begin
            errors++;
            $display("FAIL %s pc=%h: instruction=%h required %h", name, a, instruction, e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; load_start = 0; load_valid = 0; load_data = 0; load_last = 0; pc = 0;
        repeat (3) step();
        reset = 1'b1;
        step();
        checks++;
        if ({cpu_hold, load_ready, busy, length} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
            errors++;
            $display("FAIL reset_state: hold/ready/busy/len=%b/%b/%b/%0d required 1/0/0/0",
                     cpu_hold, load_ready, busy, length);
        end
        check_pc("reset_fill", 8'd0, 8'h00);
        check_pc("reset_fill", 8'd5, 8'h00);
    endtask

    task automatic test_basic_load();
        logic [7:0] b [3];
        b[0] = 8'h15; b[1] = 8'h2A; b[2] = 8'hC3;
        pulse_start();
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_data = b[i];
            load_last = (i == 2);
            exp_q.push_back(b[i]);
            checks++;
            if (load_ready !== 1'b1 || cpu_hold !== 1'b1) begin
                errors++;
                $display("FAIL basic_ready cycle %0d: ready=%b hold=%b required 1/1", i, load_ready, cpu_hold);
            end
            step();
        end
        load_valid = 1'b0; load_last = 1'b0;
        checks++;
        if ({cpu_hold, load_ready, busy, length} !== {1'b0, 1'b0, 1'b0, 9'd3}) begin
            errors++;
            $display("FAIL basic_run: hold/ready/busy/len=%b/%b/%b/%0d required 0/0/0/3",
                     cpu_hold, load_ready, busy, length);
        end
        drain_scoreboard("basic_read");
        check_pc("basic_beyond", 8'd3, 8'h00);
        check_pc("basic_wrap", 8'hFF, 8'h00);
    endtask

    task automatic test_toggle_valid();
        logic       v [5];
        logic [7:0] d [5];
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        d = '{8'h01, 8'hEE, 8'h02, 8'hEE, 8'h03};
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            load_valid = v[i];
            load_data  = d[i];
            load_last  = (i == 4);
            if (v[i]) exp_q.push_back(d[i]);
            step();
        end
        load_valid = 1'b0; load_last = 1'b0;
        checks++;
        if (length !== 9'd3 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL toggle_len: length=%0d hold=%b required 3/0", length, cpu_hold);
        end
        drain_scoreboard("toggle_read");
    endtask

    task automatic test_full_stream();
        pulse_start();
        load_valid = 1'b1;
        load_last  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            load_data = 8'(i);
            exp_q.push_back(8'(i));
            if (i == 255) begin
                checks++;
                if (load_ready !== 1'b1 || length !== 9'd255) begin
                    errors++;
                    $display("FAIL full_before_last: ready=%b length=%0d required 1/255", load_ready, length);
                end
            end
            step();
        end
        checks++;
        if ({cpu_hold, load_ready, length} !== {1'b0, 1'b0, 9'd256}) begin
            errors++;
            $display("FAIL full_auto_run: hold/ready/len=%b/%b/%0d required 0/0/256", cpu_hold, load_ready, length);
        end
        load_data = 8'hAA;
        step();
        step();
        load_valid = 1'b0;
        checks++;
        if (length !== 9'd256 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_extra_byte: length=%0d ready=%b required 256/0", length, load_ready);
        end
        drain_scoreboard("full_read");
        check_pc("full_last", 8'hFF, 8'hFF);
        check_pc("full_first", 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_hold, load_ready, busy, length} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
            errors++;
            $display("FAIL mid_load_reset: hold/ready/busy/len=%b/%b/%b/%0d required 1/0/0/0",
                     cpu_hold, load_ready, busy, length);
        end
        check_pc("mid_load_fill", 8'd0, 8'h00);
        step();
        reset = 1'b1;
        step();
        pulse_start();
        send_byte(8'h7E, 1'b1);
        check_pc("reload_one", 8'd0, 8'h7E);
        check_pc("reload_mask", 8'd1, 8'h00);
    endtask

    task automatic test_back_to_back();
        pulse_start();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b1);
        // Start and a valid byte together in RUN: start wins, the byte is dropped.
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'h55;
        step();
        load_start = 1'b0; load_valid = 1'b0;
        checks++;
        if ({cpu_hold, busy, length} !== {1'b1, 1'b1, 9'd0}) begin
            errors++;
            $display("FAIL run_restart: hold/busy/len=%b/%b/%0d required 1/1/0", cpu_hold, busy, length);
        end
        check_pc("run_restart_fill", 8'd0, 8'h00);
        send_byte(8'h10, 1'b0);
        // Start during LOADING restarts and discards the byte presented with it.
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'h66; load_last = 1'b1;
        step();
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        checks++;
        if (length !== 9'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL loading_restart: length=%0d busy=%b required 0/1", length, busy);
        end
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h4D);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h4D, 1'b1);
        checks++;
        if (length !== 9'd2 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL restart_len: length=%0d hold=%b required 2/0", length, cpu_hold);
        end
        drain_scoreboard("restart_read");
        check_pc("restart_mask", 8'd2, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_toggle_valid();
        test_full_stream();
        test_reset_mid_load();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_mem_loader

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Instruction-side partner of the 8-bit microprocessor. It holds the program memory the core reads from: the core drives pc and this block returns instruction.
- Programs are written byte-serially over a valid/ready load port.
- The block holds the core in reset (cpu_hold) until a complete program is resident.
- Sits between the board-level loader (switches/UART bridge) and the core's pc/instruction pins.

Parameters:
DEPTH, 256, number of instruction bytes stored (must be <= 2^8, matching the 8-bit pc)
FILL, 8'h00, instruction value returned for any pc >= loaded length or while not in RUN

Ports:
clk  input  1  system clock (same divided clock that drives the core)
reset  input  1  asynchronous, active-low reset
load_start  input  1  single-cycle pulse: begin a new program load
load_valid  input  1  load_data holds a valid byte
load_data  input  8  program byte
load_last  input  1  qualifies load_data as the final byte of the program
load_ready  output  1  block accepts a byte this cycle
pc  input  8  instruction address from the core
instruction  output  8  instruction byte for pc
cpu_hold  output  1  high = core must be held in reset
busy  output  1  high while in LOADING
length  output  9  number of valid bytes loaded (0..DEPTH)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, write pointer=0, length=0.
  - load_ready=0, busy=0, cpu_hold=1, instruction=FILL.
  - Memory contents are not cleared; length masks them.
- States:
  - IDLE: no program. cpu_hold=1, load_ready=0. load_start -> LOADING.
  - LOADING: busy=1, cpu_hold=1, load_ready=1.
  - RUN: cpu_hold=0, load_ready=0. load_start -> LOADING (reload).
- Entering LOADING (from any state): write pointer=0 and length=0 on the same clock edge.
- Handshake:
  - A byte transfers on a rising edge where load_valid && load_ready.
  - On transfer: mem[ptr]<=load_data, ptr<=ptr+1, length<=ptr+1.
  - load_valid without load_ready is ignored. No buffering; the sender holds data until accepted.
- Load end: LOADING -> RUN on the edge of a transfer with load_last=1, or on the transfer that makes length==DEPTH (auto-terminate). After that edge load_ready=0, so no byte beyond DEPTH is ever written.
- load_start in LOADING restarts the load: ptr=0, length=0; any byte presented that cycle is discarded.
- load_start and load_valid in the same cycle in IDLE/RUN: start wins; the byte is not accepted (load_ready was 0).
- Read path:
  - Combinational (asynchronous) read, zero latency, so instruction tracks pc within the same cycle as the core's pc update.
  - instruction = mem[pc] if state==RUN and pc < length; otherwise FILL.
- Wrap: pc is 8 bits, so the core's pc wraps 255->0 naturally. With length<256, addresses >= length return FILL.
- cpu_hold is registered and deasserts on the edge entering RUN. The core therefore starts fetching at pc=0 one cycle after the final byte.
- Reset mid-load: returns to IDLE with length=0. A partial program is never executed.
- Outputs other than instruction are driven directly from state/registers (glitch-free).

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_LOADING=2'd1, ST_RUN=2'd2) and the default FILL value.
- Sub-module: instr_ram (DEPTH x 8, synchronous write port, asynchronous read port), kept separate so it can map to distributed RAM.
- FSM, pointer and length logic stay in the top module.

Test Plan:
- Reset release, no load: cpu_hold=1, load_ready=0, length=0, instruction=8'h00 for pc=0 and pc=5.
- Load 3 bytes (8'h15, 8'h2A, 8'hC3; last on 3rd) with load_valid held high: load_ready=1 for 3 cycles. RUN on the 3rd edge; cpu_hold=0 next cycle; length=3. pc=0/1/2 -> 15/2A/C3; pc=3 -> 00.
- Load with load_valid toggled 1,0,1,0,1 (bytes 8'h01, 8'h02, 8'h03, last on 3rd): only 3 writes occur, length=3, mem[0..2]=01/02/03, no duplicates.
- Stream 256 bytes (value = index), never asserting load_last: auto-RUN on the 256th transfer, length=256, load_ready=0 afterwards. pc=8'hFF -> 8'hFF; a 257th valid byte is not written.
- Assert reset low after 2 of 4 bytes: immediate IDLE, cpu_hold=1, length=0. New load of 1 byte 8'h7E with last: pc=0 -> 7E, pc=1 -> 00.
- In RUN with length=3, pulse load_start: next cycle cpu_hold=1, busy=1, length=0, instruction=00 for pc=0.
